div_rr_arbiter: RTL and testbench

- Shares one pipelined divider (N-bit dividend, M-bit divisor, fully pipelined, one op per cycle) among K requesters.
- Arbitration is round-robin with a valid/grant handshake.
- Each issued op is tagged with its requester ID and a divide-by-zero flag; the tag travels in a shadow pipeline aligned to the divider latency.
- Results return on one shared tagged result bus. Sits between requesting engines and the divider instance.

---
 rtl/div_rr_arbiter.sv | 179 +++++++++++++++++
 tb/tb_div_rr_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_rr_arbiter.sv
// div_rr_arbiter
//   Shares one fully pipelined divider among K requesters. Requests are
//   arbitrated round-robin. Each accepted op is tagged with its requester
//   ID and a divide-by-zero flag, and the tag travels in a shadow pipeline
//   that lines up with the divider latency. Results come back on a single
//   tagged result bus, in acceptance order.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   en                  issue enable (0 blocks new grants only)
//   req                 per-requester request valid
//   req_dividend        K x N flattened dividends, requester i at [i*N +: N]
//   req_divisor         K x M flattened divisors,  requester i at [i*M +: M]
//   gnt                 one-hot combinational grant
//   div_data_rdy        registered issue strobe to the divider
//   div_dividend        registered dividend to the divider
//   div_divisor         registered divisor to the divider
//   div_rdy             divider result valid
//   div_merchant        divider quotient
//   div_remainder       divider remainder
//   res_vld             single-cycle result valid, no backpressure
//   res_id              requester ID of the result
//   res_merchant        quotient (all ones on divide by zero)
//   res_remainder       remainder (zero on divide by zero)
//   res_dz              divisor was zero
//   sync_err            sticky: a valid tag exited while div_rdy was low
//
// Handshake: requester i offers an op by holding req[i]=1 with stable-enough
// operands; the op is accepted at the rising edge where req[i] & gnt[i] = 1,
// and the operands present at that edge are the ones issued. req may drop
// or operands may change at any time before acceptance. There is no
// backpressure on the result side: res_vld is a one-cycle pulse.

module div_rr_arbiter #(
    parameter int K   = 4,
    parameter int N   = 5,
    parameter int M   = 3,
    parameter int LAT = 5,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [K-1:0]     req,
    input  logic [K*N-1:0]   req_dividend,
    input  logic [K*M-1:0]   req_divisor,
    output logic [K-1:0]     gnt,
    output logic             div_data_rdy,
    output logic [N-1:0]     div_dividend,
    output logic [M-1:0]     div_divisor,
    input  logic             div_rdy,
    input  logic [N-1:0]     div_merchant,
    input  logic [M-1:0]     div_remainder,
    output logic             res_vld,
    output logic [IDW-1:0]   res_id,
    output logic [N-1:0]     res_merchant,
    output logic [M-1:0]     res_remainder,
    output logic             res_dz,
    output logic             sync_err
);

    // Round-robin priority pointer: the requester searched first.
    logic [IDW-1:0] ptr;

    logic [IDW-1:0] gidx;
    logic           found;
    logic [K-1:0]   onehot;
    logic           accept;
    logic [N-1:0]   sel_dividend;
    logic [M-1:0]   sel_divisor;

    // Tag shadow pipeline, LAT+1 stages. Stage 0 is written at the accept
    // edge, so the tag leaves stage LAT at the same edge the divider result
    // is captured.
    logic [LAT:0]            tag_vld;
    logic [LAT:0][IDW-1:0]   tag_id;
    logic [LAT:0]            tag_dz;

    // Search upward from ptr, wrapping. Two passes avoid modulo indexing:
    // first the indices at or above ptr, then those below it.
    always_comb begin
        found  = 1'b0;
        gidx   = '0;
        onehot = '0;
        for (int i = 0; i < K; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found = 1'b1;
                gidx  = IDW'(i);
            end
        end
        for (int i = 0; i < K; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                found = 1'b1;
                gidx  = IDW'(i);
            end
        end
        if (found) begin
            onehot[gidx] = 1'b1;
        end
    end

    // Grant is forced low during reset and when issue is disabled.
    assign gnt    = (rst_n && en) ? onehot : '0;
    assign accept = |gnt;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < K; i++) begin
            if (gnt[i]) begin
                sel_dividend = req_dividend[i*N +: N];
                sel_divisor  = req_divisor[i*M +: M];
            end
        end
    end

    // Pointer and issue registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            div_data_rdy <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            div_data_rdy <= accept;
            if (accept) begin
                ptr          <= (gidx == IDW'(K-1)) ? '0 : gidx + IDW'(1);
                div_dividend <= sel_dividend;
                div_divisor  <= sel_divisor;
            end
        end
    end

    // Tag pipeline advances every cycle; there is no stall path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
            tag_dz  <= '0;
        end else begin
            tag_vld <= {tag_vld[LAT-1:0], accept};
            tag_id  <= {tag_id[LAT-1:0], gidx};
            tag_dz  <= {tag_dz[LAT-1:0], (sel_divisor == '0)};
        end
    end

    // Result capture. A divide-by-zero op ignores whatever the divider
    // returns and reports saturated quotient with zero remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_vld       <= 1'b0;
            res_id        <= '0;
            res_merchant  <= '0;
            res_remainder <= '0;
            res_dz        <= 1'b0;
            sync_err      <= 1'b0;
        end else begin
            res_vld <= tag_vld[LAT];
            if (tag_vld[LAT]) begin
                res_id <= tag_id[LAT];
                res_dz <= tag_dz[LAT];
                if (tag_dz[LAT]) begin
                    res_merchant  <= '1;
                    res_remainder <= '0;
                end else begin
                    res_merchant  <= div_merchant;
                    res_remainder <= div_remainder;
                end
            end
            // Sticky until reset: the divider failed to deliver a result
            // where the tag pipeline expected one.
            if (tag_vld[LAT] && !div_rdy) begin
                sync_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_rr_arbiter.sv
// tb_div_rr_arbiter
//   Directed bench for div_rr_arbiter with a behavioural pipelined divider.
//   Results are collected from the result bus and compared against
//   hand-computed expected results.

module tb_div_rr_arbiter;

    localparam int K   = 4;
    localparam int N   = 5;
    localparam int M   = 3;
    localparam int LAT = 5;
    localparam int IDW = 2;
    localparam int RW  = IDW + N + M + 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             en           = 1'b0;
    logic [K-1:0]     req          = '0;
    logic [K*N-1:0]   req_dividend = '0;
    logic [K*M-1:0]   req_divisor  = '0;
    logic [K-1:0]     gnt;
    logic             div_data_rdy;
    logic [N-1:0]     div_dividend;
    logic [M-1:0]     div_divisor;
    logic             div_rdy;
    logic [N-1:0]     div_merchant;
    logic [M-1:0]     div_remainder;
    logic             res_vld;
    logic [IDW-1:0]   res_id;
    logic [N-1:0]     res_merchant;
    logic [M-1:0]     res_remainder;
    logic             res_dz;
    logic             sync_err;

    div_rr_arbiter #(.K(K), .N(N), .M(M), .LAT(LAT), .IDW(IDW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .req           (req),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .gnt           (gnt),
        .div_data_rdy  (div_data_rdy),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_rdy       (div_rdy),
        .div_merchant  (div_merchant),
        .div_remainder (div_remainder),
        .res_vld       (res_vld),
        .res_id        (res_id),
        .res_merchant  (res_merchant),
        .res_remainder (res_remainder),
        .res_dz        (res_dz),
        .sync_err      (sync_err)
    );

    // ---------------- divider model ----------------
    // Samples data_rdy one edge after issue; result valid LAT edges later
    // counting the sampling edge. Not reset, so stale results can appear
    // on its outputs after a DUT reset. Divide by zero returns junk.
    logic [LAT-1:0]          m_vld    = '0;
    logic [LAT-1:0][N-1:0]   m_q      = '0;
    logic [LAT-1:0][M-1:0]   m_r      = '0;
    logic                    drop_rdy = 1'b0;

    always @(posedge clk) begin
        m_vld <= {m_vld[LAT-2:0], div_data_rdy};
        m_q   <= {m_q[LAT-2:0], (div_divisor == '0) ? N'(7)
                                : N'(div_dividend / N'(div_divisor))};
        m_r   <= {m_r[LAT-2:0], (div_divisor == '0) ? M'(5)
                                : M'(div_dividend % N'(div_divisor))};
    end

    assign div_rdy       = m_vld[LAT-1] & ~drop_rdy;
    assign div_merchant  = m_q[LAT-1];
    assign div_remainder = m_r[LAT-1];

    // ---------------- scoreboard ----------------
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];
    int total = 0;
    int bad   = 0;

    always @(negedge clk) begin
        if (res_vld === 1'b1) begin
            got_q.push_back({res_id, res_merchant, res_remainder, res_dz});
        end
    end

    function automatic logic [RW-1:0] pk(input int id, input int q,
                                         input int r, input int dz);
        return {IDW'(id), N'(q), M'(r), 1'(dz)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drain(input string tag);
        #1;
        chk({tag, " count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            chk(tag, got_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_op(input int i, input int a, input int b);
        req_dividend[i*N +: N] = N'(a);
        req_divisor[i*M +: M]  = M'(b);
    endtask

    task automatic load_burst_ops();
        set_op(0, 31, 3);
        set_op(1, 17, 4);
        set_op(2, 7, 7);
        set_op(3, 30, 7);
    endtask

    task automatic push_burst_exp(input int id);
        case (id)
            0:       exp_q.push_back(pk(0, 10, 1, 0));
            1:       exp_q.push_back(pk(1, 4, 1, 0));
            2:       exp_q.push_back(pk(2, 1, 0, 0));
            default: exp_q.push_back(pk(3, 4, 2, 0));
        endcase
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst gnt", gnt, 0);
        chk("rst div_data_rdy", div_data_rdy, 0);
        chk("rst div_dividend", div_dividend, 0);
        chk("rst div_divisor", div_divisor, 0);
        chk("rst res_vld", res_vld, 0);
        chk("rst res_id", res_id, 0);
        chk("rst res_merchant", res_merchant, 0);
        chk("rst res_remainder", res_remainder, 0);
        chk("rst res_dz", res_dz, 0);
        chk("rst sync_err", sync_err, 0);
        req = 4'b1111;
        en  = 1'b1;
        #1 chk("rst gnt held low", gnt, 0);
        req   = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single op: requester 1, 25 / 5
        set_op(1, 25, 5);
        req = 4'b0010;
        #1 chk("t1 gnt", gnt, 4'b0010);
        @(negedge clk);
        chk("t1 div_data_rdy", div_data_rdy, 1);
        chk("t1 div_dividend", div_dividend, 25);
        chk("t1 div_divisor", div_divisor, 5);
        req = '0;
        #1 chk("t1 gnt idle", gnt, 0);
        @(negedge clk);
        chk("t1 div_data_rdy pulse", div_data_rdy, 0);
        chk("t1 div_dividend hold", div_dividend, 25);
        repeat (4) @(negedge clk);
        chk("t1 res_vld early", res_vld, 0);
        @(negedge clk);
        chk("t1 res_vld", res_vld, 1);
        chk("t1 res_id", res_id, 1);
        chk("t1 res_merchant", res_merchant, 5);
        chk("t1 res_remainder", res_remainder, 0);
        chk("t1 res_dz", res_dz, 0);
        @(negedge clk);
        chk("t1 res_vld pulse", res_vld, 0);
        chk("t1 res_id hold", res_id, 1);
        exp_q.push_back(pk(1, 5, 0, 0));
        drain("t1 res");

        // Divide by zero: requester 2, 16 / 0 (pointer is 2)
        set_op(2, 16, 0);
        req = 4'b0100;
        #1 chk("t3 gnt", gnt, 4'b0100);
        @(negedge clk);
        req = '0;
        exp_q.push_back(pk(2, 31, 0, 1));
        repeat (8) @(negedge clk);
        drain("t3 res");

        // Pointer at 3, req=0101 held: 0, then 2, then 0.
        // Requester 2 changes operands while waiting.
        set_op(0, 9, 2);
        set_op(2, 5, 1);
        req = 4'b0101;
        #1 chk("t4 gnt first", gnt, 4'b0001);
        @(negedge clk);
        set_op(2, 20, 6);
        #1 chk("t4 gnt second", gnt, 4'b0100);
        @(negedge clk);
        chk("t4 sampled dividend", div_dividend, 20);
        chk("t4 sampled divisor", div_divisor, 6);
        #1 chk("t4 gnt third", gnt, 4'b0001);
        @(negedge clk);
        req = '0;
        exp_q.push_back(pk(0, 4, 1, 0));
        exp_q.push_back(pk(2, 3, 2, 0));
        exp_q.push_back(pk(0, 4, 1, 0));
        repeat (8) @(negedge clk);
        drain("t4 res");

        // Pointer at 1: a lone requester 3 op brings it back to 0.
        set_op(3, 30, 7);
        req = 4'b1000;
        #1 chk("t2 pre gnt", gnt, 4'b1000);
        @(negedge clk);
        exp_q.push_back(pk(3, 4, 2, 0));

        // Full burst for 8 cycles
        load_burst_ops();
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1 chk("t2 gnt", gnt, 32'(1 << (c % 4)));
            push_burst_exp(c % 4);
            @(negedge clk);
        end
        req = '0;
        repeat (8) @(negedge clk);
        drain("t2 res");

        // Burst with en=0 for 3 cycles in the middle
        req = 4'b1111;
        #1 chk("t5 gnt a", gnt, 4'b0001);
        push_burst_exp(0);
        @(negedge clk);
        #1 chk("t5 gnt b", gnt, 4'b0010);
        push_burst_exp(1);
        @(negedge clk);
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 chk("t5 gnt off", gnt, 0);
            @(negedge clk);
            chk("t5 div_data_rdy off", div_data_rdy, 0);
        end
        en = 1'b1;
        #1 chk("t5 gnt resume", gnt, 4'b0100);
        push_burst_exp(2);
        @(negedge clk);
        #1 chk("t5 gnt next", gnt, 4'b1000);
        push_burst_exp(3);
        @(negedge clk);
        req = '0;
        repeat (8) @(negedge clk);
        drain("t5 res");

        // Reset mid-burst with 3 ops in flight
        req = 4'b1111;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6 rst gnt", gnt, 0);
        chk("t6 rst div_data_rdy", div_data_rdy, 0);
        chk("t6 rst div_dividend", div_dividend, 0);
        chk("t6 rst res_vld", res_vld, 0);
        chk("t6 rst sync_err", sync_err, 0);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        drop_rdy = 1'b1;
        @(negedge clk);
        drop_rdy = 1'b0;
        repeat (8) @(negedge clk);
        drain("t6 stale res");
        chk("t6 sync_err clean", sync_err, 0);

        // Second run: divider withholds rdy at the expected exit
        set_op(1, 25, 5);
        req = 4'b0010;
        #1 chk("t6b gnt", gnt, 4'b0010);
        @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);
        @(negedge clk);
        drop_rdy = 1'b1;
        chk("t6b sync_err before", sync_err, 0);
        @(negedge clk);
        drop_rdy = 1'b0;
        chk("t6b res_vld", res_vld, 1);
        chk("t6b sync_err set", sync_err, 1);
        repeat (5) @(negedge clk);
        chk("t6b sync_err sticky", sync_err, 1);
        got_q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
